fft5_reorder_pp: RTL

//  Parametrised radix-5 output reorder for the 5^S-point SDF FFT chain, S chosen at run time (1..MAX_STAGES).

---
 rtl/fft5_pkg.sv | 18 +
 rtl/fft5_digit_rev_cnt.sv | 69 ++++++
 rtl/fft5_reorder_pp.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fft5_pkg.sv
// Shared types, power-of-five table and stage-count legality check for the
// radix-5 reorder buffer and its digit counter.
package fft5_pkg;

    typedef logic [2:0] digit_t;
    typedef logic [3:0] stg_t;

    localparam digit_t DIGIT_MAX = 3'd4;

    localparam int unsigned POW5 [0:7] = '{
        32'd1, 32'd5, 32'd25, 32'd125, 32'd625, 32'd3125, 32'd15625, 32'd78125
    };

    function automatic logic s_is_legal(input stg_t s, input int max_stages);
        return (s != 4'd0) && (int'(s) <= max_stages);
    endfunction

endpackage

// File: rtl/fft5_digit_rev_cnt.sv
// Base-5 sample counter whose digits, read most-significant-last, form the
// digit-reversed write address for the current frame.
module fft5_digit_rev_cnt
    import fft5_pkg::*;
#(
    parameter int MAX_STAGES = 3,
    parameter int ADDR_W     = 7,
    parameter int STG_W      = 2
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [STG_W-1:0]  i_s,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wrap,
    output logic              o_zero
);

    digit_t            r_d     [MAX_STAGES];
    digit_t            w_d_nxt [MAX_STAGES];
    logic              w_carry;
    logic              w_zero;
    logic [ADDR_W-1:0] w_acc;

    // Carry-chain increment over the S active digits plus Horner evaluation
    // of the reversed address (d[0] ends up with weight 5^(S-1)).
    always_comb begin
        w_d_nxt = r_d;
        w_carry = i_en;
        w_zero  = 1'b1;
        w_acc   = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (i < int'(i_s)) begin
                w_acc = ADDR_W'(w_acc * ADDR_W'(5)) + ADDR_W'(r_d[i]);
                if (w_carry) begin
                    if (r_d[i] == DIGIT_MAX) begin
                        w_d_nxt[i] = 3'd0;
                        w_carry    = 1'b1;
                    end else begin
                        w_d_nxt[i] = r_d[i] + 3'd1;
                        w_carry    = 1'b0;
                    end
                end else begin
                    w_d_nxt[i] = r_d[i];
                end
            end else begin
                w_d_nxt[i] = 3'd0;
            end
            w_zero = w_zero & (r_d[i] == 3'd0);
        end
        o_wrap = w_carry & (i_s != '0);
        o_addr = w_acc;
        o_zero = w_zero;
    end

    // Digit register; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_d[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_d[i] <= w_d_nxt[i];
            end
        end
    end

endmodule

// File: rtl/fft5_reorder_pp.sv
// Ping-pong reorder buffer: digit-reversed frames of 5^S samples are written
// into one bank while the previous frame streams out of the other in natural order.
module fft5_reorder_pp
    import fft5_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int MAX_STAGES = 3,
    parameter int ADDR_W     = 7,
    parameter int STG_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [STG_W-1:0] stages,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             busy,
    output logic             cfg_err
);

    localparam int DEPTH = int'(POW5[MAX_STAGES]);
    localparam int DW    = 2 * WIDTH;

    logic [STG_W-1:0]  r_s;
    logic              r_cfg_err;
    logic              r_wr_bank;
    logic              r_rd_active;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_rd_last;
    logic              r_do_en;
    logic [WIDTH-1:0]  r_do_re;
    logic [WIDTH-1:0]  r_do_im;
    logic [DW-1:0]     r_bank0 [DEPTH];
    logic [DW-1:0]     r_bank1 [DEPTH];

    logic [STG_W-1:0]  w_s_eff;
    logic              w_s_ok;
    logic              w_wr_en;
    logic              w_cnt_zero;
    logic              w_wrap;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_frame_last;
    logic [DW-1:0]     w_rd_data;

    // The stage count only tracks the port while no frame is partly written.
    always_comb begin
        w_s_eff      = w_cnt_zero ? stages : r_s;
        w_s_ok       = s_is_legal(stg_t'(w_s_eff), MAX_STAGES);
        w_wr_en      = rst & di_en & w_s_ok;
        w_frame_last = ADDR_W'(POW5[3'(w_s_eff)] - 32'd1);
    end

    fft5_digit_rev_cnt #(
        .MAX_STAGES (MAX_STAGES),
        .ADDR_W     (ADDR_W),
        .STG_W      (STG_W)
    ) u_wr_cnt (
        .clk    (clk),
        .i_clr  (~rst),
        .i_en   (w_wr_en),
        .i_s    (w_s_eff),
        .o_addr (w_wr_addr),
        .o_wrap (w_wrap),
        .o_zero (w_cnt_zero)
    );

    // Frame configuration and write-bank ping-pong.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s       <= '0;
            r_cfg_err <= 1'b0;
            r_wr_bank <= 1'b0;
        end else begin
            r_s       <= w_s_eff;
            r_cfg_err <= ~w_s_ok;
            if (w_wrap) begin
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_bank <= r_wr_bank;
            end
        end
    end

    // Bank storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_wr_bank) begin
                r_bank1[w_wr_addr] <= {di_re, di_im};
            end else begin
                r_bank0[w_wr_addr] <= {di_re, di_im};
            end
        end
    end

    // Read sequencer: a completed frame restarts the read even on its final
    // cycle, which keeps back-to-back frames gap-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_active <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_last   <= '0;
        end else if (w_wrap) begin
            r_rd_active <= 1'b1;
            r_rd_bank   <= r_wr_bank;
            r_rd_cnt    <= '0;
            r_rd_last   <= w_frame_last;
        end else if (r_rd_active) begin
            if (r_rd_cnt == r_rd_last) begin
                r_rd_active <= 1'b0;
                r_rd_cnt    <= r_rd_cnt;
            end else begin
                r_rd_active <= 1'b1;
                r_rd_cnt    <= r_rd_cnt + ADDR_W'(1);
            end
        end else begin
            r_rd_active <= 1'b0;
            r_rd_cnt    <= r_rd_cnt;
        end
    end

    assign w_rd_data = r_rd_bank ? r_bank1[r_rd_cnt] : r_bank0[r_rd_cnt];

    // Registered RAM read doubles as the output register; data holds when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_do_en <= 1'b0;
            r_do_re <= '0;
            r_do_im <= '0;
        end else begin
            r_do_en <= r_rd_active;
            if (r_rd_active) begin
                r_do_re <= w_rd_data[DW-1:WIDTH];
                r_do_im <= w_rd_data[WIDTH-1:0];
            end else begin
                r_do_re <= r_do_re;
                r_do_im <= r_do_im;
            end
        end
    end

    assign do_en   = r_do_en;
    assign do_re   = r_do_re;
    assign do_im   = r_do_im;
    assign cfg_err = r_cfg_err;
    assign busy    = ~w_cnt_zero | r_rd_active | r_do_en;

endmodule
